// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// fills the IF/ID register under a valid/ready handshake with redirect, stall and halt.
module fetch_stage #(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          INSN_W    = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = 8'h00,
  parameter int unsigned          PC_STEP   = 4,
  parameter logic [INSN_W-1:0]    HALT_INSN = 32'h00100073
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_insn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              if_ready,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INSN_W-1:0] if_insn,
  output logic [6:0]        if_opcode,
  output logic [4:0]        if_rd,
  output logic [4:0]        if_rs1,
  output logic [4:0]        if_rs2,
  output logic              halted,
  output logic              misalign_err,
  output logic [15:0]       fetch_count
);

  localparam int unsigned CNT_W = 16;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              if_valid_d;
  logic [ADDR_W-1:0] if_pc_d;
  logic [INSN_W-1:0] if_insn_d;
  logic              halted_d;
  logic              misalign_d;
  logic [CNT_W-1:0]  count_d;

  logic redirect;
  logic advance;
  logic transfer;

  // Memory is combinational, so the address is simply the current PC.
  assign imem_addr = pc_q;

  assign if_opcode = if_insn[6:0];
  assign if_rd     = if_insn[11:7];
  assign if_rs1    = if_insn[19:15];
  assign if_rs2    = if_insn[24:20];

  assign redirect = redirect_valid && !halted;
  assign advance  = !halted && (!if_valid || if_ready);
  assign transfer = if_valid && if_ready;

  // Next-state: redirect beats capture; a halted stage only drains IF/ID.
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid;
    if_pc_d    = if_pc;
    if_insn_d  = if_insn;
    halted_d   = halted;
    misalign_d = misalign_err;
    count_d    = fetch_count;

    if (redirect) begin
      pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
      if_valid_d = 1'b0;
      misalign_d = misalign_err | (|redirect_pc[1:0]);
    end else if (advance) begin
      if_pc_d    = pc_q;
      if_insn_d  = imem_insn;
      if_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(PC_STEP);
      if (imem_insn == HALT_INSN) begin
        halted_d = 1'b1;
      end
    end else if (halted && transfer) begin
      if_valid_d = 1'b0;
    end

    // A flushed entry is never counted as handed to decode.
    if (transfer && !redirect && (fetch_count != {CNT_W{1'b1}})) begin
      count_d = fetch_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_insn      <= '0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      pc_q         <= pc_d;
      if_valid     <= if_valid_d;
      if_pc        <= if_pc_d;
      if_insn      <= if_insn_d;
      halted       <= halted_d;
      misalign_err <= misalign_d;
      fetch_count  <= count_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory (8-bit byte address, 32-bit little-endian word out).
- Owns the program counter and drives the memory address.
- Captures the returned word into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Handles branch redirect/flush, downstream stall, ebreak halt, and counts issued instructions.

Parameters:
ADDR_W, 8, PC and memory address width (byte addressed)
INSN_W, 32, instruction width
RESET_PC, 8'h00, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes
HALT_INSN, 32'h00100073, encoding (ebreak) that stops fetching

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  ADDR_W  byte address to instruction memory; equals current PC
imem_insn  input  INSN_W  instruction word returned combinationally for imem_addr
redirect_valid  input  1  branch/jump taken; load redirect_pc and flush IF/ID
redirect_pc  input  ADDR_W  redirect target byte address
if_ready  input  1  decode accepts IF/ID contents this cycle
if_valid  output  1  IF/ID register holds a valid instruction
if_pc  output  ADDR_W  PC of the instruction in IF/ID
if_insn  output  INSN_W  registered instruction word
if_opcode  output  7  if_insn[6:0]
if_rd  output  5  if_insn[11:7]
if_rs1  output  5  if_insn[19:15]
if_rs2  output  5  if_insn[24:20]
halted  output  1  sticky; set after HALT_INSN is captured
misalign_err  output  1  sticky; set by a redirect with redirect_pc[1:0] != 0
fetch_count  output  16  number of instructions handed to decode (if_valid && if_ready)

Behaviour:
- Reset (synchronous, highest priority): pc=RESET_PC; if_valid=0; if_pc=0; if_insn=0; halted=0; misalign_err=0; fetch_count=0. Reset overrides redirect and handshake in the same cycle.
- imem_addr = pc combinationally. imem_insn is valid in the same cycle, so latency PC to IF/ID is 1 cycle.
- if_opcode/if_rd/if_rs1/if_rs2 are pure slices of if_insn. No extra register.
- advance = !halted && (!if_valid || if_ready).
- Priority each cycle, after reset:
  1. Redirect: redirect_valid && !halted.
     - pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
     - if_valid = 0 (flush). The word at the old pc is discarded and is not checked for HALT_INSN.
     - misalign_err |= (redirect_pc[1:0] != 0).
     - Applies even when IF/ID is stalled.
  2. Advance, no redirect:
     - if_pc = pc; if_insn = imem_insn; if_valid = 1.
     - pc = pc + PC_STEP, modulo 2^ADDR_W (0xFC wraps to 0x00 silently).
     - If imem_insn == HALT_INSN: halted = 1 from the next cycle; pc still increments.
  3. Stall: if_valid && !if_ready && !halted → pc, if_pc, if_insn, if_valid all hold.
  4. Halted:
     - No new capture; pc holds.
     - If if_valid && if_ready, if_valid = 0 next cycle.
     - Otherwise IF/ID holds until consumed.
     - redirect_valid is ignored. Only reset clears halted.
- Handshake: a transfer occurs when if_valid && if_ready at a rising edge. if_pc/if_insn are stable while if_valid && !if_ready. if_ready has no effect when if_valid=0.
- fetch_count increments by 1 per transfer, saturates at 16'hFFFF. A flushed entry (redirect while if_valid) is not counted, even if if_ready was high that cycle.
- Simultaneous redirect and HALT_INSN at pc: redirect wins; halted stays 0.
- Reset mid-stall or mid-halt: all state returns to reset values next cycle; fetch resumes from RESET_PC.

Test Plan:
- Sequential fetch: memory holds 0x00500093, 0x00A00113, 0x002081B3 at 0x00/0x04/0x08; if_ready=1 → if_valid=1 from cycle 1; if_pc=0x00,0x04,0x08 on consecutive cycles; first if_opcode=7'h13, if_rd=1, if_rs1=0; fetch_count=3 after 3 transfers.
- Stall: hold if_ready=0 for 3 cycles while if_pc=0x04 → if_pc/if_insn/imem_addr frozen (imem_addr=0x08); release → 0x08 issued next cycle, no instruction lost or duplicated.
- Redirect during stall: if_valid=1, if_ready=0, redirect_valid=1, redirect_pc=0x40 → next cycle if_valid=0, imem_addr=0x40; following cycle if_pc=0x40; fetch_count unchanged by the flush.
- Misaligned redirect: redirect_pc=0x23 → imem_addr=0x20, misalign_err=1 and stays 1 until reset.
- Halt: 0x00100073 at 0x0C → captured with if_pc=0x0C, halted=1 next cycle, imem_addr=0x10 frozen; redirect_valid then ignored; reset → halted=0, imem_addr=0x00.
- Wrap and saturation: start at pc=0xFC with if_ready=1 → next if_pc=0x00; preload fetch_count near 0xFFFF via a long run → stays 0xFFFF.
